// File: rtl/program_loader.sv
// Purpose: assembles UART bytes (MSB first) into 32-bit words and writes them to instruction memory.
// Latency: 4th rx_done sampled at edge N -> write_instruction high during cycle N+1.
// Backpressure: none; bytes arriving in IDLE/DONE/ERROR are dropped, a byte during WRITE starts the next word.
//
// Ports:
//   clk, rst                    : clock, async active-high reset
//   start                       : one-cycle load request (honoured only in IDLE)
//   rx_data, rx_done            : received byte and its one-cycle valid strobe
//   loadProgram                 : high while a load is in progress (stalls instruction fetch)
//   addressInstrucctionProgram  : word address of the current write (= word_count)
//   InstructionProgram          : assembled instruction word
//   write_instruction           : one-cycle memory write strobe
//   load_done / load_error      : normal-completion pulse / sticky inter-byte timeout flag
//   word_count                  : words written in the current or last load
module program_loader #(
    parameter int          MEM_DEPTH      = 256,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        loadProgram,
    output logic [31:0] addressInstrucctionProgram,
    output logic [31:0] InstructionProgram,
    output logic        write_instruction,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] word_count
);

    localparam logic [31:0] DEPTH      = 32'(MEM_DEPTH);
    localparam logic [31:0] DEPTH_LAST = 32'(MEM_DEPTH - 1);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] count_q, count_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        tmo_d      = tmo_q;
        count_d    = count_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                // A byte strobed together with start belongs to no program and is dropped.
                if (start) begin
                    count_d    = '0;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                    err_d      = 1'b0;
                    state_d    = RECV;
                end
            end

            RECV: begin
                if (rx_done) begin
                    word_d = {word_q[23:0], rx_data};
                    tmo_d  = '0;
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (byte_idx_q != 2'd0) begin
                    // Only a partially received word can time out; between words we wait forever.
                    if (tmo_q == TMO_LAST) begin
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end

            WRITE: begin
                if (count_q != DEPTH) begin
                    count_d = count_q + 32'd1;
                end
                // word_q is still being presented this cycle, so a new byte can shift in on the same edge.
                tmo_d = '0;
                if (rx_done) begin
                    word_d     = {word_q[23:0], rx_data};
                    byte_idx_d = 2'd1;
                end
                if ((word_q == HALT_WORD) || (count_q == DEPTH_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end

            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign loadProgram                = (state_q != IDLE);
    assign write_instruction          = (state_q == WRITE);
    assign load_done                  = (state_q == DONE);
    assign load_error                 = err_q;
    assign addressInstrucctionProgram = count_q;
    assign InstructionProgram         = word_q;
    assign word_count                 = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: vector table, hand-written corner sequences and randomized loads
// compared against a word-list model of which words a load should commit.
// Small MEM_DEPTH and TIMEOUT_CYCLES so that depth and timeout limits are reachable quickly.
module tb_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          TMO   = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        loadProgram;
    logic [31:0] addressInstrucctionProgram;
    logic [31:0] InstructionProgram;
    logic        write_instruction;
    logic        load_done;
    logic        load_error;
    logic [31:0] word_count;

    always #5 clk = ~clk;

    program_loader #(
        .MEM_DEPTH     (DEPTH),
        .HALT_WORD     (HALT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .rx_data                   (rx_data),
        .rx_done                   (rx_done),
        .loadProgram               (loadProgram),
        .addressInstrucctionProgram(addressInstrucctionProgram),
        .InstructionProgram        (InstructionProgram),
        .write_instruction         (write_instruction),
        .load_done                 (load_done),
        .load_error                (load_error),
        .word_count                (word_count)
    );

    int total = 0;
    int bad   = 0;

    // Memory-side monitor: records every write and every load_done pulse.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_pulses = 0;

    always @(negedge clk) begin
        if (write_instruction) begin
            wr_addr_q.push_back(addressInstrucctionProgram);
            wr_data_q.push_back(InstructionProgram);
        end
        if (load_done) done_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_pulses = 0;
    endtask

    typedef struct {
        logic        new_load;
        logic [31:0] word;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic        exp_done;
        logic [31:0] exp_wc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n0;
        int          k;
        int          n;
        logic [31:0] words[$];
        logic [31:0] exp_q[$];
        logic [31:0] w;

        vecs[0] = '{1'b1, 32'h2001_0005, 1'b1, 32'd0, 1'b0, 32'd1};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, 32'd2};
        vecs[2] = '{1'b1, 32'h1111_1111, 1'b1, 32'd0, 1'b0, 32'd1};
        vecs[3] = '{1'b0, 32'h2222_2222, 1'b1, 32'd1, 1'b0, 32'd2};
        vecs[4] = '{1'b0, 32'h3333_3333, 1'b1, 32'd2, 1'b0, 32'd3};
        vecs[5] = '{1'b0, 32'h4444_4444, 1'b1, 32'd3, 1'b1, 32'd4};
        vecs[6] = '{1'b0, 32'h5555_5555, 1'b0, 32'd0, 1'b0, 32'd4};

        // Reset state
        rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        #1;
        check("rst loadProgram", 32'(loadProgram), 32'd0);
        check("rst write", 32'(write_instruction), 32'd0);
        check("rst addr", addressInstrucctionProgram, 32'd0);
        check("rst instr", InstructionProgram, 32'd0);
        check("rst load_done", 32'(load_done), 32'd0);
        check("rst load_error", 32'(load_error), 32'd0);
        check("rst word_count", word_count, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Table: halt-terminated load, then depth-limited load with an extra word afterwards
        clear_mon();
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].new_load) pulse_start();
            n0 = wr_addr_q.size();
            send_word(vecs[i].word);
            cyc();
            check($sformatf("vec%0d writes", i), 32'(wr_addr_q.size() - n0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr && wr_addr_q.size() > n0) begin
                check($sformatf("vec%0d addr", i), wr_addr_q[$], vecs[i].exp_addr);
                check($sformatf("vec%0d data", i), wr_data_q[$], vecs[i].word);
            end
            check($sformatf("vec%0d load_done", i), 32'(load_done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d word_count", i), word_count, vecs[i].exp_wc);
            if (vecs[i].exp_done) begin
                cyc();
                check($sformatf("vec%0d loadProgram after done", i), 32'(loadProgram), 32'd0);
                check($sformatf("vec%0d done pulse width", i), 32'(load_done), 32'd0);
            end
        end
        check("table done pulses", 32'(done_pulses), 32'd2);

        // Timeout inside a partial word
        clear_mon();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        k = 0;
        while (!load_error && k < 200) begin
            cyc();
            k++;
        end
        check("tmo cycles after last byte", 32'(k), 32'd100);
        check("tmo loadProgram in ERROR", 32'(loadProgram), 32'd1);
        cyc();
        check("tmo loadProgram after", 32'(loadProgram), 32'd0);
        repeat (3) cyc();
        check("tmo load_error sticky", 32'(load_error), 32'd1);
        check("tmo no write", 32'(wr_addr_q.size()), 32'd0);
        check("tmo no done", 32'(done_pulses), 32'd0);
        pulse_start();
        check("tmo error cleared by start", 32'(load_error), 32'd0);
        send_word(HALT);
        cyc(); cyc();

        // Reset mid-word, then reset during WRITE
        clear_mon();
        pulse_start();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        rst = 1'b1;
        #1;
        check("midrst loadProgram", 32'(loadProgram), 32'd0);
        check("midrst write", 32'(write_instruction), 32'd0);
        check("midrst instr", InstructionProgram, 32'd0);
        check("midrst word_count", word_count, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        send_word(32'h0A0B_0C0D);
        cyc();
        check("post-rst bytes without start", 32'(wr_addr_q.size()), 32'd0);
        check("post-rst idle", 32'(loadProgram), 32'd0);
        pulse_start();
        send_word(32'hCAFE_F00D);
        cyc();
        check("post-rst write count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("post-rst addr", wr_addr_q[0], 32'd0);
            check("post-rst data", wr_data_q[0], 32'hCAFE_F00D);
        end
        send_word(32'h1234_5678);
        check("write latency strobe", 32'(write_instruction), 32'd1);
        rst = 1'b1;
        #1;
        check("rst in WRITE strobe", 32'(write_instruction), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("rst in WRITE no write", 32'(wr_addr_q.size()), 32'd1);

        // Byte arriving during WRITE starts the next word
        clear_mon();
        pulse_start();
        send_word(32'h0102_0304);
        check("write cycle strobe", 32'(write_instruction), 32'd1);
        send_byte(8'hAA);
        check("strobe one cycle", 32'(write_instruction), 32'd0);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        cyc();
        check("overlap writes", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() > 1) begin
            check("overlap word0", wr_data_q[0], 32'h0102_0304);
            check("overlap word1", wr_data_q[1], 32'hAABB_CCDD);
            check("overlap addr1", wr_addr_q[1], 32'd1);
        end
        send_word(HALT);
        repeat (3) cyc();
        check("overlap done pulses", 32'(done_pulses), 32'd1);
        check("overlap word_count", word_count, 32'd3);

        // start together with rx_done in IDLE; start again mid-load
        clear_mon();
        rx_data = 8'h99; rx_done = 1'b1; start = 1'b1;
        cyc();
        rx_done = 1'b0; start = 1'b0;
        send_byte(8'h12); send_byte(8'h34);
        pulse_start();
        send_byte(8'h56); send_byte(8'h78);
        cyc();
        check("start+byte writes", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("start+byte data", wr_data_q[0], 32'h1234_5678);
            check("start+byte addr", wr_addr_q[0], 32'd0);
        end
        check("mid start word_count", word_count, 32'd1);
        send_word(HALT);
        repeat (3) cyc();
        check("mid start final count", word_count, 32'd2);
        if (wr_addr_q.size() > 1) check("mid start halt addr", wr_addr_q[1], 32'd1);

        // Randomized loads against the word-list model
        for (int it = 0; it < 30; it++) begin
            clear_mon();
            words.delete();
            exp_q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                w = ($urandom_range(0, 3) == 0) ? HALT : 32'($urandom);
                if (j == n - 1) w = HALT;
                words.push_back(w);
            end
            // A load commits words up to and including the first halt, capped at DEPTH words.
            foreach (words[j]) begin
                exp_q.push_back(words[j]);
                if (words[j] == HALT || exp_q.size() == DEPTH) break;
            end
            pulse_start();
            foreach (words[j]) begin
                for (int b = 3; b >= 0; b--) begin
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) cyc();
                    w = words[j];
                    send_byte(w[b*8 +: 8]);
                end
            end
            repeat (12) cyc();
            check($sformatf("rand%0d writes", it), 32'(wr_addr_q.size()), 32'(exp_q.size()));
            foreach (exp_q[j]) begin
                if (j < wr_addr_q.size()) begin
                    check($sformatf("rand%0d addr%0d", it, j), wr_addr_q[j], 32'(j));
                    check($sformatf("rand%0d data%0d", it, j), wr_data_q[j], exp_q[j]);
                end
            end
            check($sformatf("rand%0d done", it), 32'(done_pulses), 32'd1);
            check($sformatf("rand%0d word_count", it), word_count, 32'(exp_q.size()));
            check($sformatf("rand%0d error", it), 32'(load_error), 32'd0);
            check($sformatf("rand%0d idle", it), 32'(loadProgram), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, which is the end-of-program instruction.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, which is the maximum idle gap between bytes inside a partially received word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin loading a program.
REQ-007 The block SHALL have port rx_data, input, 8 bits: a received UART byte.
REQ-008 The block SHALL have port rx_done, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-009 The block SHALL have port loadProgram, output, 1 bit: high while loading; it holds the instruction fetch stage off.
REQ-010 The block SHALL have port addressInstrucctionProgram, output, 32 bits: the instruction memory word address.
REQ-011 The block SHALL have port InstructionProgram, output, 32 bits: the assembled instruction word.
REQ-012 The block SHALL have port write_instruction, output, 1 bit: one-cycle write strobe to instruction memory.
REQ-013 The block SHALL have port load_done, output, 1 bit: one-cycle pulse when loading completes normally.
REQ-014 The block SHALL have port load_error, output, 1 bit: sticky timeout flag.
REQ-015 The block SHALL have port word_count, output, 32 bits: number of words written in the current or last load.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, DONE and ERROR.
REQ-017 In IDLE, start SHALL clear word_count, the byte index and load_error, and SHALL move to RECV; rx_done in IDLE SHALL be ignored.
REQ-018 In IDLE, start and rx_done asserted in the same cycle SHALL move to RECV, and that byte SHALL be discarded.
REQ-019 In RECV, each rx_done SHALL shift rx_data into the word, MSB first: byte 0 lands in [31:24] and byte 3 in [7:0].
REQ-020 On the 4th byte the FSM SHALL enter WRITE and reset the byte index to 0.
REQ-021 In WRITE, write_instruction SHALL be high for exactly 1 cycle with addressInstrucctionProgram equal to word_count and InstructionProgram equal to the assembled word; word_count SHALL increment on the same edge.
REQ-022 Write latency SHALL be: 4th rx_done sampled at edge N, write_instruction high during cycle N+1.
REQ-023 An rx_done arriving during WRITE SHALL be accepted as byte 0 of the next word.
REQ-024 From WRITE, the next state SHALL be DONE if the written word equals HALT_WORD, or if word_count equals MEM_DEPTH-1 before the increment; otherwise it SHALL be RECV.
REQ-025 The HALT_WORD itself SHALL be written to memory.
REQ-026 Words beyond MEM_DEPTH SHALL never be written; reaching the last address SHALL end the load as a normal completion.
REQ-027 The timeout counter SHALL run in RECV only while the byte index is not 0, and SHALL clear on every rx_done.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL move to ERROR and set load_error.
REQ-029 With the byte index at 0, RECV SHALL wait indefinitely.
REQ-030 In DONE, load_done SHALL be high for 1 cycle and the FSM SHALL then return to IDLE.
REQ-031 ERROR SHALL return to IDLE after 1 cycle; load_error SHALL remain set until the next start or rst.
REQ-032 loadProgram SHALL be high in RECV, WRITE, DONE and ERROR, and low in IDLE.
REQ-033 start asserted outside IDLE SHALL be ignored.
REQ-034 The byte index SHALL be 2 bits and wrap 3 -> 0 only through the WRITE transition.
REQ-035 word_count SHALL saturate at MEM_DEPTH.

Reset
REQ-036 rst SHALL asynchronously force IDLE, with all outputs, the word register, the byte index, the timeout counter and word_count at 0.
REQ-037 rst asserted mid-word or mid-WRITE SHALL abort the transfer with no write strobe after rst is asserted.
REQ-038 After rst deasserts, the block SHALL require a new start before accepting bytes.

Verification
REQ-039 Load start, then bytes 20 01 00 05, then FF FF FF FF -> writes (0, 0x20010005) and (1, 0xFFFFFFFF); load_done pulses 1 cycle; word_count = 2; loadProgram falls the cycle after load_done.
REQ-040 With MEM_DEPTH=4, send 5 non-halt words -> exactly 4 writes at addresses 0-3, load_done pulses, and the 5th word's bytes are ignored while in IDLE.
REQ-041 With TIMEOUT_CYCLES=100, send 2 bytes then idle -> ERROR 100 cycles after the last rx_done; load_error = 1, no write, loadProgram = 0 afterward, and load_error clears on the next start.
REQ-042 Assert rst after 3 bytes of a word -> all outputs 0 immediately and no write; after release, a fresh start plus 4 bytes writes address 0.
REQ-043 Assert rx_done in the WRITE cycle with 0xAA -> 0xAA appears in [31:24] of the next written word.
REQ-044 Assert start together with rx_done in IDLE, and start during RECV -> the first byte is discarded, and the mid-load start has no effect on word_count or address.
